// File: rtl/serial_encoder8x3_pkg.sv
// Shared definitions for the 8-to-3 serial encoder: default index width,
// derived vector width and the FSM state encoding.
package serial_encoder8x3_pkg;

    localparam int N_DEF = 3;
    localparam int W_DEF = 2 ** N_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/serial_encoder8x3_lsb_encoder.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit of a
// mask, plus flags telling whether any bit is set and whether exactly one is.
module lsb_encoder
    import serial_encoder8x3_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [2**N-1:0] mask,
    output logic [N-1:0]    idx,
    output logic            any,
    output logic            single
);

    localparam int W = 2 ** N;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = i[N-1:0];
            end
        end
    end

    // Clearing the lowest set bit leaves nothing exactly when one bit was set.
    always_comb begin
        any    = |mask;
        single = any & ~(|(mask & (mask - ONE)));
    end

endmodule

// File: rtl/serial_encoder8x3.sv
// Serial encoder: accepts a request vector per handshake and streams out the
// index of every set bit, lowest first, flagging the final beat. An all-zero
// vector still produces one beat, marked with out_zero.
module serial_encoder8x3
    import serial_encoder8x3_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2**N-1:0] in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out,
    output logic            out_last,
    output logic            out_zero
);

    localparam int W = 2 ** N;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_t         state;
    logic [W-1:0]   pend;
    logic [N-1:0]   low_idx;
    logic           any_set;
    logic           single_set;
    logic           busy;
    logic           out_hs;

    lsb_encoder #(.N(N)) u_lsb_encoder (
        .mask   (pend),
        .idx    (low_idx),
        .any    (any_set),
        .single (single_set)
    );

    // Beat outputs derive only from state and pend, never from the inputs.
    always_comb begin
        busy      = (state == BUSY);
        out_valid = busy;
        out       = busy ? low_idx : '0;
        out_zero  = busy & ~any_set;
        out_last  = busy & (single_set | ~any_set);
        out_hs    = out_valid & out_ready;
        // Accepting on the final beat's handshake keeps vectors back-to-back.
        in_ready  = ~busy | (out_hs & out_last);
    end

    // FSM and pending-bit register: load on accept, drop the lowest bit per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                pend  <= in;
                state <= BUSY;
            end
        end else if (out_hs) begin
            if (!out_last) begin
                pend <= pend & (pend - ONE);
            end else if (in_valid) begin
                pend <= in;
            end else begin
                pend  <= '0;
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_serial_encoder8x3.sv
// Bench for serial_encoder8x3: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a queue-based model.
module tb_serial_encoder8x3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out;
    logic       out_last;
    logic       out_zero;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
        logic       zero;
    } beat_t;

    beat_t      q[$];
    logic [7:0] vq[$];
    logic [7:0] acc;

    serial_encoder8x3 #(.N(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_last  (out_last),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: every accepted vector becomes a list of expected beats.
    task automatic push_vector(input logic [7:0] v);
        int k;
        int seen;
        beat_t b;
        k = $countones(v);
        seen = 0;
        if (v == 8'h00) begin
            b.idx = 3'd0; b.last = 1'b1; b.zero = 1'b1;
            q.push_back(b);
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    seen++;
                    b.idx = 3'(i); b.last = (seen == k); b.zero = 1'b0;
                    q.push_back(b);
                end
            end
        end
        vq.push_back(v);
    endtask

    // Compare process: DUT against the model on every cycle out of reset.
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_ready;
        if (!rst_n) begin
            q.delete();
            vq.delete();
            acc = 8'h00;
        end else begin
            exp_valid = (q.size() > 0);
            exp_ready = !exp_valid || (out_ready && q[0].last);
            chk("m_out_valid", int'(out_valid), int'(exp_valid));
            chk("m_in_ready", int'(in_ready), int'(exp_ready));
            if (exp_valid) begin
                chk("m_out", int'(out), int'(q[0].idx));
                chk("m_out_last", int'(out_last), int'(q[0].last));
                chk("m_out_zero", int'(out_zero), int'(q[0].zero));
            end
            // Decode the DUT's own stream and OR each burst back into a vector.
            if (out_valid && out_ready) begin
                if (!out_zero) acc = acc | (8'b1 << out);
                if (out_last) begin
                    if (vq.size() > 0) begin
                        chk("burst_or", int'(acc), int'(vq[0]));
                        void'(vq.pop_front());
                    end else begin
                        chk("burst_orphan", vq.size(), 1);
                    end
                    acc = 8'h00;
                end
            end
            if (exp_valid && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) push_vector(in);
        end
    end

    task automatic drive_next();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_beat(input string name, input int o, input int l,
                            input int z, input int r);
        @(negedge clk);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_out"}, int'(out), o);
        chk({name, "_last"}, int'(out_last), l);
        chk({name, "_zero"}, int'(out_zero), z);
        chk({name, "_ready"}, int'(in_ready), r);
    endtask

    initial begin
        int idx;
        int r;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in = 8'h00;
        out_ready = 1'b0;
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out", int'(out), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_zero", int'(out_zero), 0);
        drive_next();
        drive_next();
        rst_n = 1'b1;

        // 1001_0100 -> beats 2, 4, 7
        drive_next();
        in = 8'b1001_0100; in_valid = 1'b1; out_ready = 1'b1;
        drive_next();
        in_valid = 1'b0;
        lit_beat("v94_b0", 2, 0, 0, 0);
        lit_beat("v94_b1", 4, 0, 0, 0);
        lit_beat("v94_b2", 7, 1, 0, 1);
        @(negedge clk);
        chk("v94_idle", int'(out_valid), 0);

        // All-zero vector -> one zero beat
        drive_next();
        in = 8'h00; in_valid = 1'b1;
        drive_next();
        in_valid = 1'b0;
        lit_beat("v00", 0, 1, 1, 1);
        @(negedge clk);
        chk("v00_idle", int'(out_valid), 0);

        // 0xFF with out_ready pattern 1,0,0,1,0,0,...
        drive_next();
        in = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
        drive_next();
        in_valid = 1'b0;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c % 3 == 0);
            @(negedge clk);
            chk("vff_out", int'(out), idx);
            chk("vff_last", int'(out_last), int'(idx == 7));
            if (out_ready) idx++;
            if (idx == 8) break;
            drive_next();
        end
        chk("vff_count", idx, 8);
        drive_next();
        out_ready = 1'b1;
        @(negedge clk);
        chk("vff_idle", int'(out_valid), 0);

        // Back-to-back 0x01 then 0x80, no bubble
        drive_next();
        in = 8'h01; in_valid = 1'b1;
        drive_next();
        in = 8'h80;
        lit_beat("b2b_first", 0, 1, 0, 1);
        drive_next();
        in_valid = 1'b0;
        lit_beat("b2b_second", 7, 1, 0, 1);
        @(negedge clk);
        chk("b2b_idle", int'(out_valid), 0);

        // Reset in the middle of a 0x0F burst
        drive_next();
        in = 8'h0F; in_valid = 1'b1;
        drive_next();
        in_valid = 1'b0;
        lit_beat("rmid_b0", 0, 0, 0, 0);
        drive_next();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_out_valid", int'(out_valid), 0);
        chk("rmid_in_ready", int'(in_ready), 1);
        chk("rmid_out_last", int'(out_last), 0);
        drive_next();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rmid_no_residual", int'(out_valid), 0);
            chk("rmid_ready_after", int'(in_ready), 1);
        end

        // Randomized traffic
        for (int c = 0; c < 10000; c++) begin
            drive_next();
            in_valid = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 7);
            if (r == 0) in = 8'h00;
            else if (r == 1) in = 8'(1 << $urandom_range(0, 7));
            else in = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        drive_next();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) drive_next();
        @(negedge clk);
        chk("drain_beats", q.size(), 0);
        chk("drain_vectors", vq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
